// File: rtl/vga_timing_decoder.sv
// Sink-side raster decoder: recovers CounterX/CounterY/de from blank streams and locks onto a stable raster.
// Optional sync statistics outputs are enabled by defining VGA_DECODER_STATS_EN.
module vga_timing_decoder #(
    parameter int CW          = 16,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          hblank_in,
    input  logic          vblank_in,
    input  logic          hsync_in,
    input  logic          vsync_in,
    output logic [CW-1:0] CounterX,
    output logic [CW-1:0] CounterY,
    output logic          de,
    output logic          locked,
    output logic          lock_err,
    output logic [CW-1:0] line_clocks,
    output logic [CW-1:0] active_clocks,
    output logic [CW-1:0] frame_lines,
    output logic [CW-1:0] active_lines
`ifdef VGA_DECODER_STATS_EN
    ,
    output logic [CW-1:0] hsync_width,
    output logic [CW-1:0] vsync_lines,
    output logic [7:0]    lock_loss_cnt
`endif
);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] LOCK_TGT = CW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'b00,
        ST_ACQUIRE = 2'b01,
        ST_LOCKED  = 2'b10
    } state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    logic          hb_r, hb_d, vb_r, vb_d;
    logic          ls_s, fs_s, hrise_s, vrise_s, apply_s;
    logic [CW-1:0] period_s, lines_s;

    logic [CW-1:0] cnt_x_r, cnt_y_r, cnt_x_nxt_s, cnt_y_nxt_s;
    logic          fs_pend_r, fs_pend_nxt_s;
    logic [CW-1:0] line_clk_r, act_clk_r, frame_ln_r, act_ln_r;
    logic [CW-1:0] line_clk_nxt_s, act_clk_nxt_s, frame_ln_nxt_s, act_ln_nxt_s;

    logic [CW-1:0] first_per_r, first_per_nxt_s;
    logic          first_vld_r, first_vld_nxt_s;
    logic          cons_r, cons_nxt_s, cons_now_s;

    state_t        state_r, state_nxt_s;
    logic [CW-1:0] match_r, match_nxt_s;
    logic [CW-1:0] prev_line_r, prev_frame_r, prev_line_nxt_s, prev_frame_nxt_s;
    logic          prev_vld_r, prev_vld_nxt_s;
    logic [CW-1:0] lk_line_r, lk_frame_r, lk_line_nxt_s, lk_frame_nxt_s;
    logic          err_nxt_s, de_nxt_s;
    logic          de_r, locked_r, lock_err_r;

    assign ls_s     = ~hb_r & hb_d;
    assign fs_s     = ~vb_r & vb_d;
    assign hrise_s  = hb_r & ~hb_d;
    assign vrise_s  = vb_r & ~vb_d;
    assign apply_s  = ls_s & (fs_s | fs_pend_r);
    assign period_s = sat_inc(cnt_x_r);
    assign lines_s  = sat_inc(cnt_y_r);

    // Position counters, pending frame start and geometry measurements
    always_comb begin
        cnt_x_nxt_s    = cnt_x_r;
        cnt_y_nxt_s    = cnt_y_r;
        fs_pend_nxt_s  = fs_pend_r;
        line_clk_nxt_s = line_clk_r;
        act_clk_nxt_s  = act_clk_r;
        frame_ln_nxt_s = frame_ln_r;
        act_ln_nxt_s   = act_ln_r;
        if (ls_s) begin
            cnt_x_nxt_s    = CNT_ZERO;
            fs_pend_nxt_s  = 1'b0;
            line_clk_nxt_s = period_s;
            if (apply_s) begin
                cnt_y_nxt_s    = CNT_ZERO;
                frame_ln_nxt_s = lines_s;
            end else begin
                cnt_y_nxt_s    = lines_s;
            end
        end else begin
            cnt_x_nxt_s = period_s;
            if (fs_s) begin
                fs_pend_nxt_s = 1'b1;
            end else begin
                fs_pend_nxt_s = fs_pend_r;
            end
        end
        if (hrise_s) begin
            act_clk_nxt_s = period_s;
        end else begin
            act_clk_nxt_s = act_clk_r;
        end
        if (vrise_s) begin
            act_ln_nxt_s = lines_s;
        end else begin
            act_ln_nxt_s = act_ln_r;
        end
    end

    // A frame is consistent while every line period equals the first one of the frame
    assign cons_now_s = cons_r & (~first_vld_r | (period_s == first_per_r));

    // Per-frame line-period consistency tracking
    always_comb begin
        first_per_nxt_s = first_per_r;
        first_vld_nxt_s = first_vld_r;
        cons_nxt_s      = cons_r;
        if (apply_s) begin
            first_vld_nxt_s = 1'b0;
            cons_nxt_s      = 1'b1;
        end else if (ls_s) begin
            first_vld_nxt_s = 1'b1;
            cons_nxt_s      = cons_now_s;
            if (first_vld_r) begin
                first_per_nxt_s = first_per_r;
            end else begin
                first_per_nxt_s = period_s;
            end
        end else begin
            cons_nxt_s = cons_r;
        end
    end

    // Lock FSM next state and registered-output precursors
    always_comb begin
        state_nxt_s      = state_r;
        match_nxt_s      = match_r;
        prev_line_nxt_s  = prev_line_r;
        prev_frame_nxt_s = prev_frame_r;
        prev_vld_nxt_s   = prev_vld_r;
        lk_line_nxt_s    = lk_line_r;
        lk_frame_nxt_s   = lk_frame_r;
        err_nxt_s        = 1'b0;
        case (state_r)
            ST_SEARCH: begin
                if (apply_s) begin
                    state_nxt_s    = ST_ACQUIRE;
                    match_nxt_s    = CNT_ZERO;
                    prev_vld_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_SEARCH;
                end
            end
            ST_ACQUIRE: begin
                if (apply_s && cons_now_s) begin
                    if (prev_vld_r && (period_s == prev_line_r) && (lines_s == prev_frame_r)) begin
                        match_nxt_s = sat_inc(match_r);
                    end else begin
                        match_nxt_s = CNT_ONE;
                    end
                    prev_line_nxt_s  = period_s;
                    prev_frame_nxt_s = lines_s;
                    prev_vld_nxt_s   = 1'b1;
                    if (match_nxt_s >= LOCK_TGT) begin
                        state_nxt_s    = ST_LOCKED;
                        lk_line_nxt_s  = period_s;
                        lk_frame_nxt_s = lines_s;
                    end else begin
                        state_nxt_s = ST_ACQUIRE;
                    end
                end else if (apply_s) begin
                    match_nxt_s    = CNT_ZERO;
                    prev_vld_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_ACQUIRE;
                end
            end
            ST_LOCKED: begin
                if ((ls_s && (period_s != lk_line_r)) ||
                    (apply_s && (lines_s != lk_frame_r)) ||
                    ((cnt_x_r == CNT_MAX) && !ls_s)) begin
                    state_nxt_s = ST_SEARCH;
                    match_nxt_s = CNT_ZERO;
                    err_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_SEARCH;
                match_nxt_s = CNT_ZERO;
            end
        endcase
        de_nxt_s = (state_nxt_s == ST_LOCKED) && (cnt_x_nxt_s < act_clk_nxt_s) &&
                   (cnt_y_nxt_s < act_ln_nxt_s);
    end

    // State, counter and output registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hb_r         <= 1'b0;
            hb_d         <= 1'b0;
            vb_r         <= 1'b0;
            vb_d         <= 1'b0;
            cnt_x_r      <= CNT_ZERO;
            cnt_y_r      <= CNT_ZERO;
            fs_pend_r    <= 1'b0;
            line_clk_r   <= CNT_ZERO;
            act_clk_r    <= CNT_ZERO;
            frame_ln_r   <= CNT_ZERO;
            act_ln_r     <= CNT_ZERO;
            first_per_r  <= CNT_ZERO;
            first_vld_r  <= 1'b0;
            cons_r       <= 1'b1;
            state_r      <= ST_SEARCH;
            match_r      <= CNT_ZERO;
            prev_line_r  <= CNT_ZERO;
            prev_frame_r <= CNT_ZERO;
            prev_vld_r   <= 1'b0;
            lk_line_r    <= CNT_ZERO;
            lk_frame_r   <= CNT_ZERO;
            de_r         <= 1'b0;
            locked_r     <= 1'b0;
            lock_err_r   <= 1'b0;
        end else begin
            hb_r         <= hblank_in;
            hb_d         <= hb_r;
            vb_r         <= vblank_in;
            vb_d         <= vb_r;
            cnt_x_r      <= cnt_x_nxt_s;
            cnt_y_r      <= cnt_y_nxt_s;
            fs_pend_r    <= fs_pend_nxt_s;
            line_clk_r   <= line_clk_nxt_s;
            act_clk_r    <= act_clk_nxt_s;
            frame_ln_r   <= frame_ln_nxt_s;
            act_ln_r     <= act_ln_nxt_s;
            first_per_r  <= first_per_nxt_s;
            first_vld_r  <= first_vld_nxt_s;
            cons_r       <= cons_nxt_s;
            state_r      <= state_nxt_s;
            match_r      <= match_nxt_s;
            prev_line_r  <= prev_line_nxt_s;
            prev_frame_r <= prev_frame_nxt_s;
            prev_vld_r   <= prev_vld_nxt_s;
            lk_line_r    <= lk_line_nxt_s;
            lk_frame_r   <= lk_frame_nxt_s;
            de_r         <= de_nxt_s;
            locked_r     <= (state_nxt_s == ST_LOCKED);
            lock_err_r   <= err_nxt_s;
        end
    end

    assign CounterX      = cnt_x_r;
    assign CounterY      = cnt_y_r;
    assign de            = de_r;
    assign locked        = locked_r;
    assign lock_err      = lock_err_r;
    assign line_clocks   = line_clk_r;
    assign active_clocks = act_clk_r;
    assign frame_lines   = frame_ln_r;
    assign active_lines  = act_ln_r;

`ifdef VGA_DECODER_STATS_EN
    logic          hs_r, hs_d, vs_r, vs_d;
    logic [CW-1:0] hs_cnt_r, vs_cnt_r, hs_width_r, vs_lines_r;
    logic [7:0]    loss_cnt_r;

    // Sync pulse widths are captured on the falling edge of each pulse
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hs_r       <= 1'b0;
            hs_d       <= 1'b0;
            vs_r       <= 1'b0;
            vs_d       <= 1'b0;
            hs_cnt_r   <= CNT_ZERO;
            vs_cnt_r   <= CNT_ZERO;
            hs_width_r <= CNT_ZERO;
            vs_lines_r <= CNT_ZERO;
            loss_cnt_r <= 8'd0;
        end else begin
            hs_r <= hsync_in;
            hs_d <= hs_r;
            vs_r <= vsync_in;
            vs_d <= vs_r;
            if (hs_r) begin
                hs_cnt_r <= sat_inc(hs_cnt_r);
            end else if (hs_d) begin
                hs_width_r <= hs_cnt_r;
                hs_cnt_r   <= CNT_ZERO;
            end else begin
                hs_cnt_r <= CNT_ZERO;
            end
            if (vs_r && ls_s) begin
                vs_cnt_r <= sat_inc(vs_cnt_r);
            end else if (!vs_r && vs_d) begin
                vs_lines_r <= vs_cnt_r;
                vs_cnt_r   <= CNT_ZERO;
            end else begin
                vs_cnt_r <= vs_cnt_r;
            end
            if (err_nxt_s && (loss_cnt_r != 8'hFF)) begin
                loss_cnt_r <= loss_cnt_r + 8'd1;
            end else begin
                loss_cnt_r <= loss_cnt_r;
            end
        end
    end

    assign hsync_width   = hs_width_r;
    assign vsync_lines   = vs_lines_r;
    assign lock_loss_cnt = loss_cnt_r;
`else
    logic unused_sync_s;
    assign unused_sync_s = hsync_in ^ vsync_in;
`endif

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Randomized-geometry bench for vga_timing_decoder, checked cycle by cycle against a frame-level model.
module tb_vga_timing_decoder;

    localparam int CW   = 10;
    localparam int LF   = 2;
    localparam int MAXV = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          hblank_in, vblank_in, hsync_in, vsync_in;
    logic [CW-1:0] CounterX, CounterY, line_clocks, active_clocks, frame_lines, active_lines;
    logic          de, locked, lock_err;
`ifdef VGA_DECODER_STATS_EN
    logic [CW-1:0] hsync_width, vsync_lines;
    logic [7:0]    lock_loss_cnt;
`endif

    vga_timing_decoder #(.CW(CW), .LOCK_FRAMES(LF)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .hblank_in(hblank_in), .vblank_in(vblank_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .CounterX(CounterX), .CounterY(CounterY), .de(de), .locked(locked), .lock_err(lock_err),
        .line_clocks(line_clocks), .active_clocks(active_clocks),
        .frame_lines(frame_lines), .active_lines(active_lines)
`ifdef VGA_DECODER_STATS_EN
        , .hsync_width(hsync_width), .vsync_lines(vsync_lines), .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int H, HA, V, VA, HSW, VSW;
    int err_seen, de_seen;

    task automatic chk_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model state: raster position, last events, frame line list and lock bookkeeping
    int   mx, my, lc, ac, fl, al, streak, prev_line, prev_frame, lk_line, lk_frame, losses;
    bit   p1h, p2h, p1v, p2v, pend, mlocked, searching, have_prev, merr, mde;
    int   periods[$];

    function automatic int m_inc(input int a);
        return (a >= MAXV) ? MAXV : a + 1;
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; lc = 0; ac = 0; fl = 0; al = 0;
        p1h = 0; p2h = 0; p1v = 0; p2v = 0; pend = 0;
        mlocked = 0; searching = 1; have_prev = 0; streak = 0;
        merr = 0; mde = 0; periods.delete();
    endtask

    task automatic model_step(input bit h, input bit v);
        bit ls, fs, hr, vr, app, ok;
        int per, lns;
        ls  = !p1h && p2h;
        fs  = !p1v && p2v;
        hr  = p1h && !p2h;
        vr  = p1v && !p2v;
        app = ls && (fs || pend);
        per = m_inc(mx);
        lns = m_inc(my);
        merr = 0;
        if (mlocked) begin
            if ((ls && per != lk_line) || (app && lns != lk_frame) || (mx == MAXV && !ls)) begin
                merr = 1; mlocked = 0; searching = 1;
                if (losses < 255) losses++;
            end
        end else if (searching) begin
            if (app) begin searching = 0; streak = 0; have_prev = 0; end
        end else if (app) begin
            ok = 1;
            foreach (periods[i]) if (periods[i] != per) ok = 0;
            if (ok) begin
                streak = (have_prev && per == prev_line && lns == prev_frame) ? streak + 1 : 1;
                prev_line = per; prev_frame = lns; have_prev = 1;
                if (streak >= LF) begin mlocked = 1; lk_line = per; lk_frame = lns; end
            end else begin
                streak = 0; have_prev = 0;
            end
        end
        if (app) periods.delete();
        else if (ls) periods.push_back(per);
        if (ls) lc = per;
        if (hr) ac = per;
        if (app) fl = lns;
        if (vr) al = lns;
        if (ls) begin
            mx = 0; my = app ? 0 : lns; pend = 0;
        end else begin
            mx = per;
            if (fs) pend = 1;
        end
        p2h = p1h; p1h = h; p2v = p1v; p1v = v;
        mde = mlocked && (mx < ac) && (my < al);
    endtask

    task automatic step(input bit h, input bit v, input bit hs, input bit vs);
        hblank_in = h; vblank_in = v; hsync_in = hs; vsync_in = vs;
        @(posedge Clk);
        model_step(h, v);
        #1;
        chk_value("CounterX", 32'(CounterX), 32'(mx));
        chk_value("CounterY", 32'(CounterY), 32'(my));
        chk_value("de", 32'(de), 32'(mde));
        chk_value("locked", 32'(locked), 32'(mlocked));
        chk_value("lock_err", 32'(lock_err), 32'(merr));
        chk_value("line_clocks", 32'(line_clocks), 32'(lc));
        chk_value("active_clocks", 32'(active_clocks), 32'(ac));
        chk_value("frame_lines", 32'(frame_lines), 32'(fl));
        chk_value("active_lines", 32'(active_lines), 32'(al));
        if (lock_err) err_seen++;
        if (de) de_seen++;
    endtask

    // one raster frame; short_line gets H-1 clocks, early_v drops vblank one clock early, stop_y ends mid-frame
    task automatic run_frame(input int short_line, input bit early_v, input int stop_y);
        int len;
        bit vb;
        for (int y = 0; y < V && y != stop_y; y++) begin
            len = (y == short_line) ? H - 1 : H;
            for (int x = 0; x < len; x++) begin
                vb = (y >= VA) && !(early_v && y == V - 1 && x == len - 1);
                step(x >= HA, vb, (x >= HA + 2) && (x < HA + 2 + HSW), (y >= VA + 1) && (y < VA + 1 + VSW));
            end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk_value({tag, "_x"}, 32'(CounterX), 32'd0);
        chk_value({tag, "_y"}, 32'(CounterY), 32'd0);
        chk_value({tag, "_de"}, 32'(de), 32'd0);
        chk_value({tag, "_locked"}, 32'(locked), 32'd0);
        chk_value({tag, "_err"}, 32'(lock_err), 32'd0);
        chk_value({tag, "_lc"}, 32'(line_clocks), 32'd0);
        chk_value({tag, "_ac"}, 32'(active_clocks), 32'd0);
        chk_value({tag, "_fl"}, 32'(frame_lines), 32'd0);
        chk_value({tag, "_al"}, 32'(active_lines), 32'd0);
`ifdef VGA_DECODER_STATS_EN
        chk_value({tag, "_hsw"}, 32'(hsync_width), 32'd0);
        chk_value({tag, "_vsl"}, 32'(vsync_lines), 32'd0);
        chk_value({tag, "_loss"}, 32'(lock_loss_cnt), 32'd0);
`endif
    endtask

    initial begin
        int blank, vbl;
        H = $urandom_range(40, 24);  blank = $urandom_range(12, 8);  HA = H - blank;
        HSW = $urandom_range(blank - 3, 2);
        V = $urandom_range(18, 12);  vbl = $urandom_range(5, 3);     VA = V - vbl;
        VSW = $urandom_range(vbl - 1, 1);
        losses = 0;
        Reset_n = 1'b0; hblank_in = 1'b1; vblank_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        model_reset();
        #23;
        check_zero_outputs("reset");
        @(negedge Clk);
        Reset_n = 1'b1;
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);

        for (int f = 0; f < 4; f++) run_frame(-1, 0, -1);
        de_seen = 0;
        run_frame(-1, 0, -1);
        chk_value("lock_clean", 32'(locked), 32'd1);
        chk_value("meas_line", 32'(line_clocks), 32'(H));
        chk_value("meas_active", 32'(active_clocks), 32'(HA));
        chk_value("meas_frame", 32'(frame_lines), 32'(V));
        chk_value("meas_alines", 32'(active_lines), 32'(VA));
        chk_value("de_per_frame", 32'(de_seen), 32'(HA * VA));

        err_seen = 0;
        run_frame(-1, 1, -1);
        run_frame(-1, 0, -1);
        chk_value("early_v_noerr", 32'(err_seen), 32'd0);
        chk_value("early_v_lock", 32'(locked), 32'd1);

        err_seen = 0;
        run_frame($urandom_range(V - 1, 0), 0, -1);
        chk_value("short_pulses", 32'(err_seen), 32'd1);
        chk_value("short_unlock", 32'(locked), 32'd0);
        for (int f = 0; f < 3; f++) run_frame(-1, 0, -1);
        chk_value("relock", 32'(locked), 32'd1);

        for (int f = 0; f < 4; f++)
            run_frame(($urandom_range(2, 0) == 0) ? int'($urandom_range(V - 1, 0)) : -1, 1'($urandom_range(1, 0)), -1);
        for (int f = 0; f < 4; f++) run_frame(-1, 0, -1);
        chk_value("lock_before_stuck", 32'(locked), 32'd1);
`ifdef VGA_DECODER_STATS_EN
        chk_value("hsync_width", 32'(hsync_width), 32'(HSW));
        chk_value("vsync_lines", 32'(vsync_lines), 32'(VSW));
        chk_value("lock_loss_cnt", 32'(lock_loss_cnt), 32'(losses));
`endif

        err_seen = 0;
        for (int i = 0; i < MAXV + 60; i++) step(1, 0, 0, 0);
        chk_value("stuck_sat", 32'(CounterX), 32'(MAXV));
        chk_value("stuck_pulses", 32'(err_seen), 32'd1);
        chk_value("stuck_unlock", 32'(locked), 32'd0);
        chk_value("stuck_hold_lc", 32'(line_clocks), 32'(H));

        run_frame(-1, 0, -1);
        run_frame(-1, 0, -1);
        run_frame(-1, 0, V / 2);
        #2;
        Reset_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int f = 0; f < 4; f++) run_frame(-1, 0, -1);
        chk_value("relock_after_reset", 32'(locked), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
